// File: rtl/ibex_xif_imem_arbiter.sv
// Two-host round-robin arbiter for a shared instruction-memory bus.
// Tracks the issuing host of every granted request in an in-order ID FIFO so
// each response is routed back to its requester.
// Optional checking: define IBEX_XIF_IMEM_ARB_CHECK_EN to enable the sticky
// unexp_rsp_o flag and the protocol assertions.
module ibex_xif_imem_arbiter #(
  parameter int unsigned NUM_OUTSTANDING = 2,
  parameter int unsigned CW              = $clog2(NUM_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          h0_req_i,
  input  logic [31:0]   h0_addr_i,
  output logic          h0_gnt_o,
  output logic          h0_rvalid_o,
  output logic [31:0]   h0_rdata_o,
  output logic          h0_err_o,
  input  logic          h1_req_i,
  input  logic [31:0]   h1_addr_i,
  output logic          h1_gnt_o,
  output logic          h1_rvalid_o,
  output logic [31:0]   h1_rdata_o,
  output logic          h1_err_o,
  output logic          mem_req_o,
  output logic [31:0]   mem_addr_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [31:0]   mem_rdata_i,
  input  logic          mem_err_i,
  output logic [CW-1:0] outstanding_o,
  output logic          unexp_rsp_o
);

  localparam int unsigned PW = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;

  logic                       prio_q;
  logic                       lock_valid_q, lock_host_q;
  logic [NUM_OUTSTANDING-1:0] fifo_q;
  logic [PW-1:0]              rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]              count_q, count_d;

  logic sel, sel_req, not_full, push, pop, head;

  // Host selection: a stalled request stays locked to its host until granted.
  always_comb begin
    sel = 1'b0;
    if (lock_valid_q) begin
      sel = lock_host_q;
    end else if (h0_req_i && h1_req_i) begin
      sel = prio_q;
    end else if (h1_req_i) begin
      sel = 1'b1;
    end
    sel_req = sel ? h1_req_i : h0_req_i;
  end

  // Fullness uses the registered count only, so rvalid never feeds mem_req_o.
  assign not_full   = count_q < CW'(NUM_OUTSTANDING);
  assign mem_req_o  = rst_n & sel_req & not_full;
  assign mem_addr_o = sel ? h1_addr_i : h0_addr_i;
  assign h0_gnt_o   = mem_gnt_i & mem_req_o & ~sel;
  assign h1_gnt_o   = mem_gnt_i & mem_req_o & sel;

  assign push = mem_req_o & mem_gnt_i;
  assign pop  = mem_rvalid_i & (count_q != '0);
  assign head = fifo_q[rd_ptr_q];

  assign h0_rvalid_o   = pop & ~head;
  assign h1_rvalid_o   = pop & head;
  assign h0_rdata_o    = mem_rdata_i;
  assign h1_rdata_o    = mem_rdata_i;
  assign h0_err_o      = mem_err_i;
  assign h1_err_o      = mem_err_i;
  assign outstanding_o = count_q;

  // Outstanding count: push and pop in the same cycle cancel.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Arbitration state: round-robin pointer and request lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q       <= 1'b0;
      lock_valid_q <= 1'b0;
      lock_host_q  <= 1'b0;
    end else begin
      lock_valid_q <= mem_req_o & ~mem_gnt_i;
      lock_host_q  <= sel;
      if (push) begin
        prio_q <= ~sel;
      end
    end
  end

  // In-order ID FIFO recording which host owns each outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q <= (wr_ptr_q == PW'(NUM_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(NUM_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
    end
  end

`ifdef IBEX_XIF_IMEM_ARB_CHECK_EN
  logic unexp_q;

  // Sticky flag for a response arriving with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unexp_q <= 1'b0;
    end else if (mem_rvalid_i && (count_q == '0)) begin
      unexp_q <= 1'b1;
    end
  end

  assign unexp_rsp_o = unexp_q;

  a_no_unexp_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rvalid_i && (count_q == '0)));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    !(h0_gnt_o && h1_gnt_o));
  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req_o && !mem_gnt_i) |=> $stable(mem_addr_o));
`else
  assign unexp_rsp_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_xif_imem_arbiter.sv
// Directed self-checking bench for ibex_xif_imem_arbiter (NUM_OUTSTANDING=2).
// Inputs change just after negedge; outputs are checked 1ns later.
module tb_ibex_xif_imem_arbiter;

  logic        clk, rst_n;
  logic        h0_req, h1_req;
  logic [31:0] h0_addr, h1_addr;
  logic        h0_gnt, h1_gnt, h0_rvalid, h1_rvalid, h0_err, h1_err;
  logic [31:0] h0_rdata, h1_rdata;
  logic        mem_req, mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_rdata;
  logic [1:0]  outstanding;
  logic        unexp;

  int total = 0;
  int bad   = 0;

`ifdef IBEX_XIF_IMEM_ARB_CHECK_EN
  localparam logic ExpUnexp = 1'b1;
`else
  localparam logic ExpUnexp = 1'b0;
`endif

  ibex_xif_imem_arbiter #(.NUM_OUTSTANDING(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .h0_req_i     (h0_req),
    .h0_addr_i    (h0_addr),
    .h0_gnt_o     (h0_gnt),
    .h0_rvalid_o  (h0_rvalid),
    .h0_rdata_o   (h0_rdata),
    .h0_err_o     (h0_err),
    .h1_req_i     (h1_req),
    .h1_addr_i    (h1_addr),
    .h1_gnt_o     (h1_gnt),
    .h1_rvalid_o  (h1_rvalid),
    .h1_rdata_o   (h1_rdata),
    .h1_err_o     (h1_err),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .mem_err_i    (mem_err),
    .outstanding_o(outstanding),
    .unexp_rsp_o  (unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge, where new inputs are applied.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    h0_req = 0; h1_req = 0; mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    cyc();
    rst_n = 1;
  endtask

  initial begin
    h0_addr = '0; h1_addr = '0; mem_rdata = '0;
    idle_inputs();
    rst_n = 0;
    h0_req = 1;
    #1;
    // Outputs forced low during reset even with a host requesting.
    check_val("rst_mem_req", 32'(mem_req), 0);
    check_val("rst_h0_gnt", 32'(h0_gnt), 0);
    check_val("rst_outstanding", 32'(outstanding), 0);
    check_val("rst_unexp", 32'(unexp), 0);
    cyc(); cyc();
    rst_n = 1; h0_req = 0;

    // Single host-0 transaction.
    cyc();
    h0_req = 1; h0_addr = 32'h1000; mem_gnt = 1;
    #1;
    check_val("t1_mem_req", 32'(mem_req), 1);
    check_val("t1_mem_addr", mem_addr, 32'h1000);
    check_val("t1_h0_gnt", 32'(h0_gnt), 1);
    check_val("t1_h1_gnt", 32'(h1_gnt), 0);
    cyc();
    h0_req = 0; mem_gnt = 0;
    #1;
    check_val("t1_out1", 32'(outstanding), 1);
    check_val("t1_no_rv_early", 32'(h0_rvalid), 0);
    cyc();
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    check_val("t1_h0_rvalid", 32'(h0_rvalid), 1);
    check_val("t1_h1_rvalid", 32'(h1_rvalid), 0);
    check_val("t1_h0_rdata", h0_rdata, 32'hDEADBEEF);
    check_val("t1_h0_err", 32'(h0_err), 0);
    cyc();
    mem_rvalid = 0;
    #1;
    check_val("t1_out0", 32'(outstanding), 0);

    // Both hosts every cycle, memory always granting.
    do_reset();
    h0_req = 1; h1_req = 1; h0_addr = 32'hA0; h1_addr = 32'hB0; mem_gnt = 1;
    #1;
    check_val("t2_g0_h0", 32'(h0_gnt), 1);
    check_val("t2_g0_h1", 32'(h1_gnt), 0);
    cyc(); #1;
    check_val("t2_g1_h1", 32'(h1_gnt), 1);
    check_val("t2_g1_h0", 32'(h0_gnt), 0);
    check_val("t2_g1_addr", mem_addr, 32'hB0);
    cyc(); #1;
    check_val("t2_full_req", 32'(mem_req), 0);
    check_val("t2_full_h0gnt", 32'(h0_gnt), 0);
    check_val("t2_full_out", 32'(outstanding), 2);
    cyc();
    h0_req = 0; h1_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h11;
    #1;
    check_val("t2_rv1_h0", 32'(h0_rvalid), 1);
    check_val("t2_rv1_h1", 32'(h1_rvalid), 0);
    cyc();
    mem_rdata = 32'h22; mem_err = 1;
    #1;
    check_val("t2_rv2_h1", 32'(h1_rvalid), 1);
    check_val("t2_rv2_h0", 32'(h0_rvalid), 0);
    check_val("t2_rv2_err", 32'(h1_err), 1);
    check_val("t2_rv2_data", h1_rdata, 32'h22);
    cyc();
    mem_rvalid = 0; mem_err = 0;
    #1;
    check_val("t2_out0", 32'(outstanding), 0);

    // Stalled host-1 request must hold its address while host 0 joins.
    h1_req = 1; h1_addr = 32'h2000; h0_addr = 32'h3000;
    #1;
    check_val("t3_c1_addr", mem_addr, 32'h2000);
    check_val("t3_c1_gnt", 32'(h1_gnt), 0);
    cyc();
    h0_req = 1;
    #1;
    check_val("t3_c2_addr", mem_addr, 32'h2000);
    check_val("t3_c2_h0gnt", 32'(h0_gnt), 0);
    cyc(); #1;
    check_val("t3_c3_addr", mem_addr, 32'h2000);
    cyc();
    mem_gnt = 1;
    #1;
    check_val("t3_c4_h1gnt", 32'(h1_gnt), 1);
    check_val("t3_c4_h0gnt", 32'(h0_gnt), 0);
    cyc();
    h1_req = 0;
    #1;
    check_val("t3_c5_h0gnt", 32'(h0_gnt), 1);
    check_val("t3_c5_addr", mem_addr, 32'h3000);
    cyc();
    h0_req = 0; mem_gnt = 0;
    #1;
    check_val("t3_out2", 32'(outstanding), 2);

    // Full FIFO: pop and request in the same cycle, grant only next cycle.
    h1_req = 1; h1_addr = 32'h4000; mem_gnt = 1; mem_rvalid = 1;
    #1;
    check_val("t4_full_req", 32'(mem_req), 0);
    check_val("t4_full_gnt", 32'(h1_gnt), 0);
    check_val("t4_pop_h1rv", 32'(h1_rvalid), 1);
    cyc();
    mem_rvalid = 0;
    #1;
    check_val("t4_out1", 32'(outstanding), 1);
    check_val("t4_next_gnt", 32'(h1_gnt), 1);
    cyc();
    h1_req = 0; mem_gnt = 0;
    #1;
    check_val("t4_out2", 32'(outstanding), 2);
    mem_rvalid = 1;
    #1;
    check_val("t4_drain1_h0", 32'(h0_rvalid), 1);
    cyc(); #1;
    check_val("t4_drain2_h1", 32'(h1_rvalid), 1);
    cyc();
    mem_rvalid = 0;
    #1;
    check_val("t4_out0", 32'(outstanding), 0);

    // Unexpected response with nothing outstanding.
    mem_rvalid = 1;
    #1;
    check_val("t5_h0rv", 32'(h0_rvalid), 0);
    check_val("t5_h1rv", 32'(h1_rvalid), 0);
    cyc();
    mem_rvalid = 0;
    #1;
    check_val("t5_unexp", 32'(unexp), 32'(ExpUnexp));
    check_val("t5_out", 32'(outstanding), 0);
    cyc(); #1;
    check_val("t5_unexp_sticky", 32'(unexp), 32'(ExpUnexp));

    // Asynchronous reset with two outstanding requests.
    h0_req = 1; mem_gnt = 1;
    cyc(); cyc();
    #1;
    check_val("t6_out2", 32'(outstanding), 2);
    #1;
    rst_n = 0;
    #1;
    check_val("t6_rst_out", 32'(outstanding), 0);
    check_val("t6_rst_unexp", 32'(unexp), 0);
    check_val("t6_rst_req", 32'(mem_req), 0);
    idle_inputs();
    cyc();
    rst_n = 1;
    mem_rvalid = 1;
    #1;
    check_val("t6_post_rv_h0", 32'(h0_rvalid), 0);
    check_val("t6_post_rv_h1", 32'(h1_rvalid), 0);
    cyc();
    mem_rvalid = 0; h0_req = 1; h1_req = 1; mem_gnt = 1;
    #1;
    check_val("t6_post_unexp", 32'(unexp), 32'(ExpUnexp));
    check_val("t6_prio_h0", 32'(h0_gnt), 1);
    cyc();
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety timeout so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
